// File: rtl/peripheral_spram_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM arbiter: FSM states,
// Wishbone cycle-type codes and the round-robin scan used by the chooser.
package peripheral_spram_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC      = 3'b000;
  localparam logic [2:0] CTI_CONST_BURST  = 3'b001;
  localparam logic [2:0] CTI_INCR_BURST   = 3'b010;
  localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // rr_pick works on a fixed 8-wide request vector; callers zero-pad narrower ones.
  localparam int RR_MAX_NM = 8;
  localparam int RR_IDX_W  = 3;

  // Returns {found, index}; scans last+1, last+2, ... modulo nm.
  function automatic logic [RR_IDX_W:0] rr_pick(
    input logic [RR_MAX_NM-1:0] req,
    input logic [RR_IDX_W-1:0]  last,
    input int                   nm
  );
    logic [RR_IDX_W:0] result;
    int                cand;
    result = '0;
    cand   = 0;
    for (int k = 1; k <= RR_MAX_NM; k++) begin
      if (k <= nm) begin
        cand = (int'(last) + k) % nm;
        if (!result[RR_IDX_W] && req[cand[RR_IDX_W-1:0]]) begin
          result = {1'b1, cand[RR_IDX_W-1:0]};
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/peripheral_arb_rr_apb4.sv
// Combinational round-robin chooser: picks the first requester after the
// previously served master, as an index and as a one-hot vector.
module peripheral_arb_rr_apb4
  import peripheral_spram_arbiter_pkg::*;
#(
  parameter int NM = 2,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NM-1:0] gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [RR_IDX_W:0] pick;

  always_comb begin
    pick       = rr_pick(RR_MAX_NM'(req), RR_IDX_W'(last), NM);
    any        = pick[RR_IDX_W];
    gnt_idx    = IW'(pick[RR_IDX_W-1:0]);
    gnt_onehot = any ? (NM'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/peripheral_spram_arbiter_apb4.sv
// Round-robin arbiter sharing one single-port RAM slave among NM masters.
// The grant is held for the whole bus cycle; a watchdog can error out hung cycles.
module peripheral_spram_arbiter_apb4
  import peripheral_spram_arbiter_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               apb4_clk_i,
  input  logic               apb4_rstn_i,
  input  logic [NM*AW-1:0]   apb4_m_adr_i,
  input  logic [NM*DW-1:0]   apb4_m_dat_i,
  input  logic [NM*DW/8-1:0] apb4_m_sel_i,
  input  logic [NM-1:0]      apb4_m_we_i,
  input  logic [NM*2-1:0]    apb4_m_bte_i,
  input  logic [NM*3-1:0]    apb4_m_cti_i,
  input  logic [NM-1:0]      apb4_m_cyc_i,
  input  logic [NM-1:0]      apb4_m_stb_i,
  output logic [NM-1:0]      apb4_m_ack_o,
  output logic [NM-1:0]      apb4_m_err_o,
  output logic [NM*DW-1:0]   apb4_m_dat_o,
  output logic [AW-1:0]      apb4_s_adr_o,
  output logic [DW-1:0]      apb4_s_dat_o,
  output logic [DW/8-1:0]    apb4_s_sel_o,
  output logic               apb4_s_we_o,
  output logic [1:0]         apb4_s_bte_o,
  output logic [2:0]         apb4_s_cti_o,
  output logic               apb4_s_cyc_o,
  output logic               apb4_s_stb_o,
  input  logic               apb4_s_ack_i,
  input  logic               apb4_s_err_i,
  input  logic [DW-1:0]      apb4_s_dat_i
);

  localparam int  IW         = (NM > 1) ? $clog2(NM) : 1;
  localparam int  SW         = DW / 8;
  localparam int  WW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit  WDOG_EN    = (TIMEOUT > 0);
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT);

  arb_state_e    state;
  logic [IW-1:0] grant;
  logic [NM-1:0] grant_oh;
  logic [IW-1:0] last;
  logic [WW-1:0] wdog;

  logic [NM-1:0] rr_onehot;
  logic [IW-1:0] rr_idx;
  logic          rr_any;

  logic [AW-1:0] adr_arr [NM];
  logic [DW-1:0] dat_arr [NM];
  logic [SW-1:0] sel_arr [NM];
  logic [1:0]    bte_arr [NM];
  logic [2:0]    cti_arr [NM];

  logic busy;
  logic cyc_g;
  logic stb_g;
  logic wdog_fire;

  peripheral_arb_rr_apb4 #(
    .NM (NM),
    .IW (IW)
  ) u_rr (
    .req        (apb4_m_cyc_i),
    .last       (last),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .any        (rr_any)
  );

  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign adr_arr[i] = apb4_m_adr_i[i*AW +: AW];
    assign dat_arr[i] = apb4_m_dat_i[i*DW +: DW];
    assign sel_arr[i] = apb4_m_sel_i[i*SW +: SW];
    assign bte_arr[i] = apb4_m_bte_i[i*2 +: 2];
    assign cti_arr[i] = apb4_m_cti_i[i*3 +: 3];
  end

  assign busy  = (state == BUSY);
  assign cyc_g = apb4_m_cyc_i[grant];
  assign stb_g = apb4_m_stb_i[grant];

  // Slave side follows the granted master; nothing reaches the slave while idle.
  assign apb4_s_adr_o = adr_arr[grant];
  assign apb4_s_dat_o = dat_arr[grant];
  assign apb4_s_sel_o = sel_arr[grant];
  assign apb4_s_we_o  = apb4_m_we_i[grant];
  assign apb4_s_bte_o = bte_arr[grant];
  assign apb4_s_cti_o = cti_arr[grant];
  assign apb4_s_cyc_o = busy & cyc_g;
  assign apb4_s_stb_o = busy & cyc_g & stb_g;

  assign wdog_fire = WDOG_EN && busy && (wdog == WDOG_LIMIT);

  // Slave err and a watchdog expiry in the same cycle collapse into one pulse.
  assign apb4_m_ack_o = {NM{busy & apb4_s_ack_i}} & grant_oh;
  assign apb4_m_err_o = {NM{busy & (apb4_s_err_i | wdog_fire)}} & grant_oh;
  assign apb4_m_dat_o = {NM{apb4_s_dat_i}};

  always_ff @(posedge apb4_clk_i or negedge apb4_rstn_i) begin
    if (!apb4_rstn_i) begin
      state    <= IDLE;
      grant    <= '0;
      grant_oh <= '0;
      last     <= IW'(NM - 1);
      wdog     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (rr_any) begin
            grant    <= rr_idx;
            grant_oh <= rr_onehot;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // Only the owner dropping cyc ends the tenure, regardless of cti/bte.
          if (!cyc_g) begin
            state <= IDLE;
            last  <= grant;
            wdog  <= '0;
          end else if (apb4_s_ack_i || apb4_s_err_i || wdog_fire) begin
            wdog <= '0;
          end else if (WDOG_EN && apb4_s_stb_o && (wdog != WDOG_LIMIT)) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
